gated_logic_pipe: RTL and testbench

- Parametrised, pipelined successor to the ALU's single-enable 32-bit AND gate.
- Computes a selectable bitwise operation on two WIDTH-bit operands, then gates the result per lane with an enable mask (the old single `ty` enable becomes one enable bit per lane).
- Two register stages with valid/ready flow control, so it can feed the ALU result mux or a streaming datapath that stalls.

---
 rtl/gated_logic_pkg.sv | 18 +
 rtl/gated_logic_pipe_if.sv | 32 +++
 rtl/gated_logic_core.sv | 49 ++++
 rtl/gated_logic_pipe.sv | 99 +++++++++
 tb/tb_gated_logic_pipe.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gated_logic_pkg.sv
// Shared op encoding for the gated bitwise-logic pipeline.
// Combinational definitions only: no latency, no flow control.
package gated_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NOR    = 3'b011,
    OP_ANDN   = 3'b100,
    OP_PASS_A = 3'b101,
    OP_PASS_B = 3'b110,
    OP_CLR    = 3'b111
  } op_e;

endpackage

// File: rtl/gated_logic_pipe_if.sv
// Operand-in / result-out stream bundle; master drives operands and out_ready.
// Pure wiring: no latency; valid/ready on both sides.
interface gated_logic_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
);
  import gated_logic_pkg::*;

  localparam int NL = WIDTH / LANE_W;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic [NL-1:0]    gate;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (
    output in_valid, a, b, op, gate, out_ready,
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, a, b, op, gate, out_ready,
    output in_ready, out_valid, y, zero
  );

endinterface

// File: rtl/gated_logic_core.sv
// Bitwise op mux, per-lane enable gating and zero detect.
// Purely combinational: zero latency, no backpressure of its own.
module gated_logic_core
  import gated_logic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [OP_W-1:0]         op,
  input  logic [WIDTH/LANE_W-1:0] gate,
  output logic [WIDTH-1:0]        y,
  output logic                    zero
);

  localparam int NL = WIDTH / LANE_W;

  if (WIDTH % LANE_W != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of LANE_W");
  end

  logic [WIDTH-1:0] raw;

  always_comb begin
    raw = '0;
    case (op)
      OP_AND:    raw = a & b;
      OP_OR:     raw = a | b;
      OP_XOR:    raw = a ^ b;
      OP_NOR:    raw = ~(a | b);
      OP_ANDN:   raw = a & ~b;
      OP_PASS_A: raw = a;
      OP_PASS_B: raw = b;
      default:   raw = '0;
    endcase
  end

  // Each gate bit masks one LANE_W-wide slice of the raw result.
  always_comb begin
    y = '0;
    for (int i = 0; i < NL; i++) begin
      y[i*LANE_W +: LANE_W] = raw[i*LANE_W +: LANE_W] & {LANE_W{gate[i]}};
    end
  end

  assign zero = (y == '0);

endmodule

// File: rtl/gated_logic_pipe.sv
// Two-stage valid/ready pipeline around gated_logic_core; 2-cycle latency, 1 beat/cycle.
// Ready chain is combinational back to in_ready, so a full pipe stalls without bubbles.
module gated_logic_pipe
  import gated_logic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  gated_logic_pipe_if.slave  bus,
  output logic [CNT_W-1:0]   xfer_cnt
);

  localparam int NL = WIDTH / LANE_W;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic [NL-1:0]    gate;
  } s1_t;

  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic             accept;
  logic             s1_adv;
  logic             emit;
  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;

  assign s2_ready = !s2_valid || bus.out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign accept   = bus.in_valid && s1_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign emit     = s2_valid && bus.out_ready;

  assign s1_d = '{a: bus.a, b: bus.b, op: bus.op, gate: bus.gate};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  gated_logic_core #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W)
  ) u_core (
    .a    (s1_q.a),
    .b    (s1_q.b),
    .op   (s1_q.op),
    .gate (s1_q.gate),
    .y    (core_y),
    .zero (core_zero)
  );

  // Result is only reloaded on advance, so it holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      y_q      <= core_y;
      zero_q   <= core_zero;
    end else if (emit) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (emit) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s2_valid;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_gated_logic_pipe.sv
// Bench for gated_logic_pipe: vector table, hand-written corner sequences and a
// random stream scored against a queue-based reference model.
module tb_gated_logic_pipe;
  import gated_logic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] xfer_cnt;

  gated_logic_pipe_if #(.WIDTH(32), .LANE_W(8)) bus ();

  gated_logic_pipe #(.WIDTH(32), .LANE_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  g;
    logic [31:0] ey;
    logic        ez;
  } vec_t;

  vec_t        tbl [10];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_y [$];
  logic        got_z [$];
  logic [3:0]  cnt_m = 4'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_y = 32'd0;
  logic        prev_z = 1'b0;
  logic        stop = 1'b0;
  logic        scramble = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [3:0] g);
    logic [31:0] r;
    logic [31:0] m;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a & ~b;
      3'd5:    r = a;
      3'd6:    r = b;
      default: r = 32'd0;
    endcase
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (g[i]) m = m | (32'hFF << (8 * i));
    return r & m;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: occupancy = beats accepted but not yet delivered.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cnt_m      = 4'd0;
      prev_stall = 1'b0;
    end else begin
      check("xfer_cnt", 32'(xfer_cnt), 32'(cnt_m));
      check("in_ready", 32'(bus.in_ready),
            32'(!(exp_q.size() == 2 && !bus.out_ready)));
      if (exp_q.size() != 1)
        check("out_valid_occ", 32'(bus.out_valid), 32'(exp_q.size() == 2));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_y", bus.y, prev_y);
        check("stall_zero", 32'(bus.zero), 32'(prev_z));
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_y", bus.y, e);
        check("sb_zero", 32'(bus.zero), 32'(e == 32'd0));
        got_y.push_back(bus.y);
        got_z.push_back(bus.zero);
        cnt_m = cnt_m + 4'd1;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.op, bus.gate));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.y;
      prev_z     = bus.zero;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tbv,
                      input logic [2:0] top, input logic [3:0] tg);
    int n;
    n = 0;
    bus.a = ta; bus.b = tbv; bus.op = top; bus.gate = tg;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.a = $urandom; bus.b = $urandom;
        bus.op = 3'($urandom); bus.gate = 4'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int t0;
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, OP_PASS_A, 4'b0101, 32'h00FF_00FF, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, OP_PASS_A, 4'b0000, 32'h0000_0000, 1'b1};
    tbl[2] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_AND,    4'b1111, 32'h0204_0608, 1'b0};
    tbl[3] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_OR,     4'b1111, 32'h1F3F_5F7F, 1'b0};
    tbl[4] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_XOR,    4'b1111, 32'h1D3B_5977, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_NOR,    4'b1111, 32'hE0C0_A080, 1'b0};
    tbl[6] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_ANDN,   4'b1111, 32'h1030_5070, 1'b0};
    tbl[7] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_PASS_A, 4'b1111, 32'h1234_5678, 1'b0};
    tbl[8] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_PASS_B, 4'b1111, 32'h0F0F_0F0F, 1'b0};
    tbl[9] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_CLR,    4'b1111, 32'h0000_0000, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = '0; bus.gate = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", bus.y, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat: result visible two cycles after it is presented.
    send(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 4'b1111);
    @(negedge clk);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_y", bus.y, 32'hF000_F000);
    check("lat_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    check("lat_cnt", 32'(xfer_cnt), 32'd1);
    @(posedge clk); #1;

    start = got_y.size();
    t0 = cyc;
    for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].g);
    check("tbl_throughput", 32'(cyc - t0), 32'd10);
    drain();
    check("tbl_count", 32'(got_y.size() - start), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (start + i < got_y.size()) begin
        check($sformatf("tbl_y[%0d]", i), got_y[start+i], tbl[i].ey);
        check($sformatf("tbl_zero[%0d]", i), 32'(got_z[start+i]), 32'(tbl[i].ez));
      end
    end

    // Backpressure: out_ready low for cycles 3..6 of a 5-beat stream.
    do_reset();
    scramble = 1'b1;
    start = got_y.size();
    fork
      begin
        for (int c = 0; c < 12; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          if (c == 4) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
          end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 5; k++)
          send($urandom, $urandom, 3'($urandom), 4'($urandom));
      end
    join
    drain();
    check("bp_delivered", 32'(got_y.size() - start), 32'd5);
    check("bp_xfer_cnt", 32'(xfer_cnt), 32'd5);

    // Counter wrap with a 4-bit counter: 17 transfers leave it at 1.
    do_reset();
    for (int k = 0; k < 17; k++) send($urandom, $urandom, 3'($urandom), 4'hF);
    drain();
    check("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Reset with two beats held inside the pipe.
    bus.out_ready = 1'b0;
    send(32'hAAAA_AAAA, 32'h5555_5555, OP_OR, 4'hF);
    send(32'h1111_1111, 32'h2222_2222, OP_XOR, 4'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_y", bus.y, 32'd0);
    check("mid_rst_zero", 32'(bus.zero), 32'd1);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random stream with random gaps and random downstream stalls.
    do_reset();
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
          send($urandom, $urandom, 3'($urandom), 4'($urandom));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
